uv_edge_buffer: RTL and testbench

Upstream neighbour supplier for the chroma DC predictor. Per 8x8 chroma macroblock pair (U and V), it presents the top neighbour row and the left neighbour column plus the macroblock coordinates, then pulses start to the predictor. It then absorbs the reconstructed U/V rows of that macroblock and keeps two things for later macroblocks: the right-most column (left neighbour for MB x+1) and the bottom row (top neighbour for MB at the same x in the next MB row, held in a line buffer).

---
 rtl/uv_edge_buffer_pkg.sv | 18 +
 rtl/uv_edge_buffer_line_ram.sv | 29 ++
 rtl/uv_edge_buffer.sv | 117 +++++++++++
 tb/tb_uv_edge_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uv_edge_buffer_pkg.sv
// Shared constants and state encoding for the chroma U/V neighbour buffer.
package uv_edge_buffer_pkg;

    localparam int BIT_WIDTH  = 8;
    localparam int BLOCK_SIZE = 8;
    localparam int BLOCK_NUM  = 10;
    localparam int ROW_W      = $clog2(BLOCK_SIZE);
    localparam int PIX_W      = BIT_WIDTH * BLOCK_SIZE;
    localparam int LINE_W     = 2 * PIX_W;

    typedef enum logic [3:0] {
        ST_IDLE = 4'h1,
        ST_RD   = 4'h2,
        ST_OUT  = 4'h4,
        ST_REC  = 4'h8
    } state_t;

endpackage

// File: rtl/uv_edge_buffer_line_ram.sv
// Single-port line buffer: one entry per MB column, holding {bottom V row, bottom U row}.
module uv_line_ram
    import uv_edge_buffer_pkg::*;
#(
    parameter int AW = BLOCK_NUM,
    parameter int DW = LINE_W
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write on enable+we, otherwise a registered read; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/uv_edge_buffer.sv
// Supplies top/left chroma neighbours to the DC predictor and captures the
// reconstructed edges of each macroblock for its right and lower neighbours.
module uv_edge_buffer
    import uv_edge_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [BLOCK_NUM-1:0] req_x,
    input  logic [BLOCK_NUM-1:0] req_y,
    output logic                 req_ready,
    output logic                 pred_start,
    output logic [BLOCK_NUM-1:0] pred_x,
    output logic [BLOCK_NUM-1:0] pred_y,
    output logic [PIX_W-1:0]     top_u,
    output logic [PIX_W-1:0]     top_v,
    output logic [PIX_W-1:0]     left_u,
    output logic [PIX_W-1:0]     left_v,
    input  logic                 rec_valid,
    input  logic [ROW_W-1:0]     rec_row,
    input  logic [PIX_W-1:0]     rec_u,
    input  logic [PIX_W-1:0]     rec_v,
    output logic                 err
);

    state_t              state;
    state_t              state_next;
    logic [ROW_W-1:0]    row_cnt;
    logic [PIX_W-1:0]    left_u_reg;
    logic [PIX_W-1:0]    left_v_reg;
    logic                top_en;
    logic                accept;
    logic                last_row;
    logic                ram_en;
    logic                ram_we;
    logic [LINE_W-1:0]   ram_rdata;

    assign accept   = (state == ST_REC) && rec_valid && (rec_row == row_cnt);
    assign last_row = accept && (row_cnt == ROW_W'(BLOCK_SIZE - 1));

    // Top neighbour comes straight from the RAM read register, gated by the
    // row-0 flag captured alongside it so both change only when OUT is entered.
    assign top_u = top_en ? ram_rdata[PIX_W-1:0]      : '0;
    assign top_v = top_en ? ram_rdata[LINE_W-1:PIX_W] : '0;

    uv_line_ram u_line_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (pred_x),
        .wdata ({rec_v, rec_u}),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; req is only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req) state_next = ST_RD;
            ST_RD:   state_next = ST_OUT;
            ST_OUT:  state_next = ST_REC;
            ST_REC:  if (last_row) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs and RAM control decoded from the current state.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        pred_start = (state == ST_OUT);
        ram_en     = (state == ST_RD) || last_row;
        ram_we     = last_row;
    end

    // Request capture, neighbour snapshot, row tracking and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_x     <= '0;
            pred_y     <= '0;
            left_u     <= '0;
            left_v     <= '0;
            left_u_reg <= '0;
            left_v_reg <= '0;
            top_en     <= 1'b0;
            row_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            if (state == ST_IDLE && req) begin
                pred_x <= req_x;
                pred_y <= req_y;
            end
            if (state == ST_RD) begin
                left_u <= (pred_x != '0) ? left_u_reg : '0;
                left_v <= (pred_x != '0) ? left_v_reg : '0;
                top_en <= (pred_y != '0);
            end
            if (accept) begin
                left_u_reg[int'(row_cnt)*BIT_WIDTH +: BIT_WIDTH] <= rec_u[PIX_W-1 -: BIT_WIDTH];
                left_v_reg[int'(row_cnt)*BIT_WIDTH +: BIT_WIDTH] <= rec_v[PIX_W-1 -: BIT_WIDTH];
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end
            if (state == ST_REC && rec_valid && rec_row != row_cnt) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uv_edge_buffer.sv
// Directed bench for uv_edge_buffer with hand-computed neighbour values.
module tb_uv_edge_buffer;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic        req_ready;
    logic        pred_start;
    logic [9:0]  pred_x;
    logic [9:0]  pred_y;
    logic [63:0] top_u;
    logic [63:0] top_v;
    logic [63:0] left_u;
    logic [63:0] left_v;
    logic        rec_valid;
    logic [2:0]  rec_row;
    logic [63:0] rec_u;
    logic [63:0] rec_v;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int start_cnt = 0;

    uv_edge_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .pred_start (pred_start),
        .pred_x     (pred_x),
        .pred_y     (pred_y),
        .top_u      (top_u),
        .top_v      (top_v),
        .left_u     (left_u),
        .left_v     (left_v),
        .rec_valid  (rec_valid),
        .rec_row    (rec_row),
        .rec_u      (rec_u),
        .rec_v      (rec_v),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count predictor start pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (pred_start) start_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Row r of a test macroblock: byte k = (16r + k) XOR base.
    function automatic logic [63:0] mk_row(input logic [7:0] base, input logic [2:0] r);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            v[k*8 +: 8] = 8'((16 * int'(r)) + k) ^ base;
        end
        return v;
    endfunction

    task automatic send_row(input logic [2:0] r, input logic [63:0] u, input logic [63:0] v);
        rec_valid = 1'b1;
        rec_row   = r;
        rec_u     = u;
        rec_v     = v;
        step();
        rec_valid = 1'b0;
    endtask

    task automatic send_rows(input logic [7:0] base, input int n);
        for (int r = 0; r < n; r++) begin
            send_row(3'(r), mk_row(base, 3'(r)), mk_row(base ^ 8'h80, 3'(r)));
        end
    endtask

    task automatic issue_req(input logic [9:0] x, input logic [9:0] y);
        req   = 1'b1;
        req_x = x;
        req_y = y;
        step();
        req   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        req_x     = '0;
        req_y     = '0;
        rec_valid = 1'b0;
        rec_row   = '0;
        rec_u     = '0;
        rec_v     = '0;
        step();
        step();

        // Reset values
        check_output("rst_req_ready", req_ready, 1);
        check_output("rst_pred_start", pred_start, 0);
        check_output("rst_pred_xy", {pred_x, pred_y}, 0);
        check_output("rst_top", {top_u, top_v}, 0);
        check_output("rst_left", {left_u, left_v}, 0);
        check_output("rst_err", err, 0);
        rst_n = 1'b1;
        step();

        // Stray reconstructed row while idle is ignored
        send_row(3'd0, 64'h1111, 64'h2222);
        check_output("idle_rec_ready", req_ready, 1);
        check_output("idle_rec_err", err, 0);

        // MB (0,0)
        issue_req(10'd0, 10'd0);
        check_output("mb00_rd_ready", req_ready, 0);
        check_output("mb00_rd_start", pred_start, 0);
        step();
        check_output("mb00_out_start", pred_start, 1);
        check_output("mb00_out_xy", {pred_x, pred_y}, 0);
        check_output("mb00_out_top", {top_u, top_v}, 0);
        check_output("mb00_out_left", {left_u, left_v}, 0);
        step();
        check_output("mb00_rec_start", pred_start, 0);
        send_rows(8'h00, 7);
        check_output("mb00_row6_ready", req_ready, 0);
        send_row(3'd7, mk_row(8'h00, 3'd7), mk_row(8'h80, 3'd7));
        check_output("mb00_done_ready", req_ready, 1);
        check_output("mb00_done_err", err, 0);
        check_output("mb00_start_cnt", start_cnt, 1);

        // MB (1,0) with req held high through RD/OUT/REC pointing elsewhere
        req   = 1'b1;
        req_x = 10'd1;
        req_y = 10'd0;
        step();
        req_x = 10'd5;
        req_y = 10'd3;
        step();
        check_output("mb10_out_start", pred_start, 1);
        check_output("mb10_out_x", pred_x, 1);
        check_output("mb10_out_y", pred_y, 0);
        check_output("mb10_left_u", left_u, 64'h7767574737271707);
        check_output("mb10_left_v", left_v, 64'hF7E7D7C7B7A79787);
        check_output("mb10_top", {top_u, top_v}, 0);
        step();
        send_rows(8'h05, 8);
        req = 1'b0;
        check_output("mb10_done_ready", req_ready, 1);
        check_output("mb10_held_xy", {pred_x, pred_y}, {10'd1, 10'd0});
        check_output("mb10_start_cnt", start_cnt, 2);
        check_output("mb10_err", err, 0);

        // MB (0,1): top from MB (0,0) bottom row, then an out-of-order row
        issue_req(10'd0, 10'd1);
        step();
        check_output("mb01_out_start", pred_start, 1);
        check_output("mb01_top_u", top_u, 64'h7776757473727170);
        check_output("mb01_top_v", top_v, 64'hF7F6F5F4F3F2F1F0);
        check_output("mb01_left", {left_u, left_v}, 0);
        check_output("mb01_y", pred_y, 1);
        step();
        send_row(3'd2, mk_row(8'h33, 3'd2), mk_row(8'hB3, 3'd2));
        check_output("mb01_err_set", err, 1);
        check_output("mb01_err_ready", req_ready, 0);
        send_rows(8'h0A, 7);
        check_output("mb01_row6_ready", req_ready, 0);
        send_row(3'd7, mk_row(8'h0A, 3'd7), mk_row(8'h8A, 3'd7));
        check_output("mb01_done_ready", req_ready, 1);
        check_output("mb01_err_sticky", err, 1);

        // MB (1,1): left from MB (0,1) right column, top from MB (1,0) bottom row
        issue_req(10'd1, 10'd1);
        step();
        check_output("mb11_left_u", left_u, 64'h7D6D5D4D3D2D1D0D);
        check_output("mb11_left_v", left_v, 64'hFDEDDDCDBDAD9D8D);
        check_output("mb11_top_u", top_u, 64'h7273707176777475);
        check_output("mb11_top_v", top_v, 64'hF2F3F0F1F6F7F4F5);
        step();
        send_rows(8'h0C, 4);
        check_output("mb11_partial_ready", req_ready, 0);

        // Reset in the middle of REC
        rst_n = 1'b0;
        #1;
        check_output("midrst_ready", req_ready, 1);
        check_output("midrst_start", pred_start, 0);
        check_output("midrst_xy", {pred_x, pred_y}, 0);
        check_output("midrst_top", {top_u, top_v}, 0);
        check_output("midrst_left", {left_u, left_v}, 0);
        check_output("midrst_err", err, 0);
        step();
        rst_n = 1'b1;
        step();

        // MB (1,2): line buffer column 1 still holds MB (1,0), left registers cleared
        issue_req(10'd1, 10'd2);
        step();
        check_output("mb12_start", pred_start, 1);
        check_output("mb12_xy", {pred_x, pred_y}, {10'd1, 10'd2});
        check_output("mb12_top_u", top_u, 64'h7273707176777475);
        check_output("mb12_top_v", top_v, 64'hF2F3F0F1F6F7F4F5);
        check_output("mb12_left", {left_u, left_v}, 0);
        step();
        check_output("final_start_cnt", start_cnt, 5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
